// File: rtl/rinv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rinv_pkg
// Brief    : Shared states and constants for the R-inverse back-substitution
//            sequencer (optional build macro: RINV_SINGULAR_CHECK_EN).
// Revision : 1.0
// ============================================================================
package rinv_pkg;

    localparam int RINV_MAX_N = 16;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RECIP_REQ  = 3'd1,
        RECIP_WAIT = 3'd2,
        MAC        = 3'd3,
        SCALE      = 3'd4,
        DRAIN      = 3'd5,
        FINISH     = 3'd6
    } rinv_state_t;

    localparam logic WR_SRC_DIAG  = 1'b1;
    localparam logic WR_SRC_SCALE = 1'b0;

endpackage
`default_nettype wire

// File: rtl/rinv_wr_pipe.sv
`default_nettype none
// ============================================================================
// Module   : rinv_wr_pipe
// Brief    : LAT-deep {valid,row,col} delay line aligning scale results with
//            their Rinv write-back slot.
// Revision : 1.0
// ============================================================================
module rinv_wr_pipe
    import rinv_pkg::*;
#(
    parameter int LAT   = 3,
    parameter int IDX_W = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_row,
    input  logic [IDX_W-1:0] in_col,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_row,
    output logic [IDX_W-1:0] out_col,
    output logic             empty_next
);

    logic             valid_q [LAT];
    logic             valid_d [LAT];
    logic [IDX_W-1:0] row_q   [LAT];
    logic [IDX_W-1:0] row_d   [LAT];
    logic [IDX_W-1:0] col_q   [LAT];
    logic [IDX_W-1:0] col_d   [LAT];

    always_comb begin
        valid_d[0] = in_valid;
        row_d[0]   = in_valid ? in_row : '0;
        col_d[0]   = in_valid ? in_col : '0;
        for (int s = 1; s < LAT; s++) begin
            valid_d[s] = valid_q[s-1];
            row_d[s]   = row_q[s-1];
            col_d[s]   = col_q[s-1];
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int s = 0; s < LAT; s++) begin
                valid_q[s] <= 1'b0;
                row_q[s]   <= '0;
                col_q[s]   <= '0;
            end
        end else begin
            for (int s = 0; s < LAT; s++) begin
                valid_q[s] <= valid_d[s];
                row_q[s]   <= row_d[s];
                col_q[s]   <= col_d[s];
            end
        end
    end

    // Nothing queued behind the write-back stage: the pipe is empty next cycle.
    always_comb begin
        empty_next = 1'b1;
        for (int s = 0; s < LAT - 1; s++) begin
            if (valid_q[s]) empty_next = 1'b0;
        end
    end

    assign out_valid = valid_q[LAT-1];
    assign out_row   = row_q[LAT-1];
    assign out_col   = col_q[LAT-1];

endmodule
`default_nettype wire

// File: rtl/r_inverse_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : r_inverse_sequencer
// Brief    : Back-substitution sequencer for inverting an NxN upper-triangular
//            R; optional singular detection under RINV_SINGULAR_CHECK_EN.
// Revision : 1.0
// ============================================================================
module r_inverse_sequencer
    import rinv_pkg::*;
#(
    parameter  int N     = 4,
    parameter  int LAT   = 3,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    output logic             busy,
    output logic             recip_req,
    output logic [IDX_W-1:0] recip_idx,
    input  logic             recip_done,
    output logic             mac_valid,
    output logic             mac_first,
    output logic             mac_last,
    output logic [IDX_W-1:0] row_idx,
    output logic [IDX_W-1:0] col_idx,
    output logic [IDX_W-1:0] k_idx,
    output logic             scale_valid,
    output logic             wr_en,
    output logic             wr_diag,
    output logic [IDX_W-1:0] wr_row,
    output logic [IDX_W-1:0] wr_col,
    output logic             done
`ifdef RINV_SINGULAR_CHECK_EN
    ,
    input  logic             recip_zero,
    output logic             singular_err
`endif
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    rinv_state_t      state_q, state_d;
    logic [IDX_W-1:0] i_q, i_d;
    logic [IDX_W-1:0] dist_q, dist_d;
    logic [IDX_W-1:0] k_q, k_d;
    logic [IDX_W-1:0] col_j;
    logic             diag_wr;
    logic             pipe_valid;
    logic [IDX_W-1:0] pipe_row, pipe_col;
    logic             pipe_empty_next;
`ifdef RINV_SINGULAR_CHECK_EN
    logic             singular_q, singular_d;
`endif

    assign col_j = i_q + dist_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            i_q     <= '0;
            dist_q  <= '0;
            k_q     <= '0;
`ifdef RINV_SINGULAR_CHECK_EN
            singular_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            dist_q  <= dist_d;
            k_q     <= k_d;
`ifdef RINV_SINGULAR_CHECK_EN
            singular_q <= singular_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        dist_d      = dist_q;
        k_d         = k_q;
        busy        = (state_q != IDLE) && (state_q != FINISH);
        recip_req   = 1'b0;
        recip_idx   = '0;
        mac_valid   = 1'b0;
        mac_first   = 1'b0;
        mac_last    = 1'b0;
        row_idx     = '0;
        col_idx     = '0;
        k_idx       = '0;
        scale_valid = 1'b0;
        done        = 1'b0;
        diag_wr     = 1'b0;
`ifdef RINV_SINGULAR_CHECK_EN
        singular_d  = singular_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RECIP_REQ;
                    i_d     = '0;
`ifdef RINV_SINGULAR_CHECK_EN
                    singular_d = 1'b0;
`endif
                end
            end
            RECIP_REQ: begin
                recip_req = 1'b1;
                recip_idx = i_q;
                state_d   = RECIP_WAIT;
            end
            RECIP_WAIT: begin
                if (recip_done) begin
`ifdef RINV_SINGULAR_CHECK_EN
                    if (recip_zero) begin
                        singular_d = 1'b1;
                        state_d    = FINISH;
                    end else
`endif
                    begin
                        diag_wr = 1'b1;
                        if (i_q != LAST_IDX) begin
                            i_d     = i_q + IDX_W'(1);
                            state_d = RECIP_REQ;
                        end else if (N == 1) begin
                            state_d = FINISH;
                        end else begin
                            state_d = MAC;
                            dist_d  = IDX_W'(1);
                            i_d     = '0;
                            k_d     = IDX_W'(1);
                        end
                    end
                end
            end
            MAC: begin
                mac_valid = 1'b1;
                mac_first = (k_q == i_q + IDX_W'(1));
                mac_last  = (k_q == col_j);
                row_idx   = i_q;
                col_idx   = col_j;
                k_idx     = k_q;
                if (k_q == col_j) state_d = SCALE;
                else              k_d     = k_q + IDX_W'(1);
            end
            SCALE: begin
                scale_valid = 1'b1;
                row_idx     = i_q;
                col_idx     = col_j;
                // Elements of one diagonal are independent, so the next MAC follows directly.
                if (col_j == LAST_IDX) begin
                    state_d = DRAIN;
                end else begin
                    state_d = MAC;
                    i_d     = i_q + IDX_W'(1);
                    k_d     = i_q + IDX_W'(1) + IDX_W'(1);
                end
            end
            DRAIN: begin
                if (pipe_empty_next) begin
                    if (dist_q == LAST_IDX) begin
                        state_d = FINISH;
                    end else begin
                        state_d = MAC;
                        dist_d  = dist_q + IDX_W'(1);
                        i_d     = '0;
                        k_d     = IDX_W'(1);
                    end
                end
            end
            FINISH: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    rinv_wr_pipe #(
        .LAT   (LAT),
        .IDX_W (IDX_W)
    ) u_wr_pipe (
        .CLK        (CLK),
        .RST        (RST),
        .in_valid   (scale_valid),
        .in_row     (i_q),
        .in_col     (col_j),
        .out_valid  (pipe_valid),
        .out_row    (pipe_row),
        .out_col    (pipe_col),
        .empty_next (pipe_empty_next)
    );

    // Diagonal writes only occur while the scale pipe is idle, so they never collide.
    assign wr_en   = diag_wr | pipe_valid;
    assign wr_diag = diag_wr ? WR_SRC_DIAG : WR_SRC_SCALE;
    assign wr_row  = diag_wr ? i_q : pipe_row;
    assign wr_col  = diag_wr ? i_q : pipe_col;

`ifdef RINV_SINGULAR_CHECK_EN
    assign singular_err = singular_q;
`endif

endmodule
`default_nettype wire

// File: doc/r_inverse_sequencer.md
Name: r_inverse_sequencer

Overview:
- Parametrised control FSM that sequences inversion of an N×N upper-triangular complex R matrix (QR-based matrix inversion) by back-substitution.
- Drives index/strobe signals to a shared datapath: reciprocal CORDIC, complex MAC, scaling multiplier and Rinv register file.
- Replaces fixed 4×4 mux-select sequencing with index generation for any N, with latency-aware write-back and dependency draining.

Parameters:
N, 4, matrix dimension (1..16)
LAT, 3, cycles from scale_valid to result ready at the Rinv store (1..8)
IDX_W, $clog2(N) min 1, index width (derived localparam, not overridable)

Ports:
CLK  in  1  clock
RST  in  1  reset, asynchronous, active-low
start  in  1  begin inversion; sampled only in IDLE
busy  out  1  high from the cycle after accepted start until done
recip_req  out  1  one-cycle request to reciprocal CORDIC for R[recip_idx][recip_idx]
recip_idx  out  IDX_W  diagonal index for reciprocal
recip_done  in  1  reciprocal result valid; honoured only in RECIP_WAIT
mac_valid  out  1  complex MAC issue: acc += R[row][k] * Rinv[k][col]
mac_first  out  1  clear accumulator before this product
mac_last  out  1  final product for current element
row_idx  out  IDX_W  element row i
col_idx  out  IDX_W  element column j
k_idx  out  IDX_W  summation index k
scale_valid  out  1  datapath computes -Rinv[i][i] * acc for (row_idx, col_idx)
wr_en  out  1  write Rinv[wr_row][wr_col]
wr_diag  out  1  write source: 1 = reciprocal result, 0 = scale pipeline
wr_row  out  IDX_W  write row
wr_col  out  IDX_W  write column
done  out  1  one-cycle completion pulse

Behaviour:
- Reset: state IDLE; all outputs 0; write pipeline cleared. Reset mid-operation aborts immediately; no further writes.
- IDLE: start=1 → RECIP_REQ, i=0. start during non-IDLE states is ignored.
- RECIP_REQ: recip_req=1, recip_idx=i for one cycle → RECIP_WAIT.
- RECIP_WAIT: on recip_done, in the same cycle assert wr_en=1, wr_diag=1, wr_row=wr_col=i.
  - i<N-1: i++, go to RECIP_REQ.
  - Otherwise: N=1 → FINISH; else → MAC with d=1, i=0.
- Off-diagonal order: diagonal distance d=1..N-1; within d, i=0..N-1-d, j=i+d.
- MAC: one cycle per k=i+1..j, so d cycles total. mac_valid=1; mac_first on k=i+1; mac_last on k=j. row_idx=i, col_idx=j, k_idx=k held valid with mac_valid. After k=j → SCALE.
- SCALE: one cycle, scale_valid=1 with row_idx=i, col_idx=j. Element (i,j) enters a LAT-deep write shift register.
  - More elements in d: next cycle is MAC of the next element; no bubble.
  - Last element of d: → DRAIN.
- Write-back: wr_en=1, wr_diag=0, wr_row/wr_col=(i,j) exactly LAT cycles after that element's scale_valid. The pipeline shifts every cycle regardless of state.
- DRAIN: wait until the write pipeline is empty, i.e. the cycle after the last wr_en of d.
  - d<N-1: d++, i=0, → MAC.
  - Otherwise → FINISH.
  - Guarantees Rinv[k][j] of distance d-1 is written before any MAC of distance d.
- FINISH: done=1 for one cycle, busy=0, → IDLE.
- busy=1 in every state except IDLE and FINISH.
- Index outputs are don't-care when their strobe is low; the implementation drives 0.
- Counts per run: N recip_req, N(N-1)/2 scale_valid, (N³-N)/6 mac_valid, N(N+1)/2 wr_en.

Optional Feature:
RINV_SINGULAR_CHECK_EN:
- Defined: adds input recip_zero (1 bit, qualified by recip_done) and output singular_err (1 bit, sticky, cleared on accepted start).
- recip_zero=1 with recip_done suppresses that diagonal write, sets singular_err, and goes to FINISH (done pulses) without issuing any MAC.
- Undefined: ports absent; every recip_done is treated as a valid result.

Decomposition:
- Package rinv_pkg holds the state enum (IDLE, RECIP_REQ, RECIP_WAIT, MAC, SCALE, DRAIN, FINISH), the write-source constants WR_SRC_DIAG/WR_SRC_SCALE, and the max-N constant.
- Sub-module rinv_wr_pipe: LAT-deep shift register of {valid,row,col} with an empty flag. Used by DRAIN.

Test Plan:
- N=4, LAT=3, recip_done returned 2 cycles after each req → 4 reqs in order idx 0..3.
  - 10 mac_valid, 6 scale_valid, 10 wr_en.
  - Write order: (0,0),(1,1),(2,2),(3,3),(0,1),(1,2),(2,3),(0,2),(1,3),(0,3).
  - One done pulse.
- N=2, LAT=3, recip_done immediate:
  - Cycles 1-2 of the off-diagonal phase: mac_valid (k=1, first=last=1), then scale_valid (0,1).
  - wr_en (0,1) 3 cycles after scale_valid; done the cycle after.
- N=1 → 1 recip_req and 1 diagonal write, done the next cycle, zero mac_valid.
- Drain check, N=3, LAT=5:
  - First mac_valid of d=2 occurs exactly 1 cycle after wr_en of (1,2), never earlier.
  - start pulsed while busy is ignored.
- RST low during MAC of N=4 → all outputs 0 next cycle.
  - Fresh start afterwards → full correct sequence; no stale writes emerge from the pipeline.
- RINV_SINGULAR_CHECK_EN, N=4, recip_zero on idx 2:
  - Writes (0,0),(1,1) only; singular_err=1; done pulses; zero mac_valid.
